fp8_add_sequencer: RTL and testbench

- Multi-cycle controller that sequences one shared 8-bit operand-select path (2:1 byte mux), one shifter and one adder to add two 8-bit floating-point operands.
- FSM drives operand swap, serial mantissa alignment, add/subtract and serial normalisation.
- valid/ready handshake on both input and output. One operation in flight.
- Sits between the operand source and the result consumer in the floating adder.

---
 rtl/fp8_add_sequencer.sv | 149 ++++++++++++++
 tb/tb_fp8_add_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fp8_add_sequencer.sv
// Multi-cycle 8-bit floating-point adder controller: swaps operands by magnitude,
// aligns serially, adds/subtracts and normalises serially, with valid/ready on both sides.
module fp8_add_sequencer #(
  parameter int BIAS      = 3,
  parameter int MAX_ALIGN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic       ovf,
  output logic       unf
);

  // Largest exponent code of the 3-bit field is 2*BIAS+1.
  localparam logic [2:0] EXP_MAX = 3'(2 * BIAS + 1);

  typedef enum logic [2:0] {IDLE, SWAP, ALIGN, ADD, NORM, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  a_r, b_r;
  logic [4:0]  sig_big, sig_small;
  logic [2:0]  exp_w, diff;
  logic [5:0]  sum;
  logic        sign_big, eff_sub;

  logic        zero_a, zero_b, a_big;
  logic [7:0]  big_op, small_op;
  logic [2:0]  diff_sw;

  always_comb begin
    zero_a   = (a_r[6:4] == 3'd0);
    zero_b   = (b_r[6:4] == 3'd0);
    a_big    = (a_r[6:0] >= b_r[6:0]);
    big_op   = a_big ? a_r : b_r;
    small_op = a_big ? b_r : a_r;
    diff_sw  = big_op[6:4] - small_op[6:4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = SWAP;
      SWAP: begin
        if (zero_a || zero_b)     state_nxt = DONE;
        else if (diff_sw != 3'd0) state_nxt = ALIGN;
        else                      state_nxt = ADD;
      end
      ALIGN: if (diff > 3'(MAX_ALIGN) || diff == 3'd1) state_nxt = ADD;
      ADD:   state_nxt = NORM;
      NORM: begin
        if (sum[5])              state_nxt = (exp_w == EXP_MAX) ? DONE : NORM;
        else if (sum == 6'd0)    state_nxt = DONE;
        else if (!sum[4])        state_nxt = (exp_w == 3'd1) ? DONE : NORM;
        else                     state_nxt = DONE;
      end
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      sig_big   <= '0;
      sig_small <= '0;
      exp_w     <= '0;
      diff      <= '0;
      sum       <= '0;
      sign_big  <= 1'b0;
      eff_sub   <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= b;
          ovf <= 1'b0;
          unf <= 1'b0;
        end
        SWAP: begin
          if (zero_a && zero_b) result <= '0;
          else if (zero_a)      result <= b_r;
          else if (zero_b)      result <= a_r;
          sig_big   <= {1'b1, big_op[3:0]};
          sig_small <= {1'b1, small_op[3:0]};
          exp_w     <= big_op[6:4];
          diff      <= diff_sw;
          sign_big  <= big_op[7];
          eff_sub   <= big_op[7] ^ small_op[7];
        end
        ALIGN: begin
          if (diff > 3'(MAX_ALIGN)) begin
            sig_small <= '0;
            diff      <= '0;
          end else begin
            sig_small <= sig_small >> 1;
            diff      <= diff - 3'd1;
          end
        end
        ADD: sum <= eff_sub ? ({1'b0, sig_big} - {1'b0, sig_small})
                            : ({1'b0, sig_big} + {1'b0, sig_small});
        NORM: begin
          if (sum[5]) begin
            if (exp_w == EXP_MAX) begin
              result <= {sign_big, 7'h7F};
              ovf    <= 1'b1;
            end else begin
              sum   <= sum >> 1;
              exp_w <= exp_w + 3'd1;
            end
          end else if (sum == 6'd0) begin
            result <= '0;
          end else if (!sum[4]) begin
            if (exp_w == 3'd1) begin
              result <= '0;
              unf    <= 1'b1;
            end else begin
              sum   <= sum << 1;
              exp_w <= exp_w - 3'd1;
            end
          end else begin
            result <= {sign_big, exp_w, sum[3:0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_add_sequencer.sv
// Directed bench for fp8_add_sequencer: arithmetic reference model, per-cycle compare
// of handshake and result, plus hand-computed vectors pinning result and latency.
module tb_fp8_add_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0, b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic       ovf, unf;

  int nvec = 0;
  int nerr = 0;

  fp8_add_sequencer #(.BIAS(3), .MAX_ALIGN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic       ovf;
    logic       unf;
    logic [7:0] lat;
  } mres_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: values as integer significands scaled by powers of two.
  function automatic mres_t model(input logic [7:0] x, input logic [7:0] y);
    mres_t r;
    int ex, ey, vx, vy, sb, ss, eb, es, d, s, e, na, ns;
    bit sgn, sub, done;
    ex = int'(x[6:4]);
    ey = int'(y[6:4]);
    r = '0;
    if (ex == 0 && ey == 0) begin r.res = 8'h00; r.lat = 8'd1; return r; end
    if (ex == 0) begin r.res = y; r.lat = 8'd1; return r; end
    if (ey == 0) begin r.res = x; r.lat = 8'd1; return r; end
    vx = (16 + int'(x[3:0])) << ex;
    vy = (16 + int'(y[3:0])) << ey;
    if (vx >= vy) begin
      sb = 16 + int'(x[3:0]); eb = ex; sgn = x[7];
      ss = 16 + int'(y[3:0]); es = ey;
    end else begin
      sb = 16 + int'(y[3:0]); eb = ey; sgn = y[7];
      ss = 16 + int'(x[3:0]); es = ex;
    end
    sub = x[7] ^ y[7];
    d = eb - es;
    na = (d == 0) ? 0 : (d <= 4) ? d : 1;
    ss = (d > 4) ? 0 : (ss >> d);
    s = sub ? sb - ss : sb + ss;
    e = eb;
    ns = 0;
    done = 0;
    while (!done) begin
      if (s >= 32) begin
        if (e == 7) begin r.res = {sgn, 7'h7F}; r.ovf = 1'b1; done = 1; end
        else begin s = s >> 1; e++; ns++; end
      end else if (s == 0) begin
        r.res = 8'h00; done = 1;
      end else if (s < 16) begin
        if (e == 1) begin r.res = 8'h00; r.unf = 1'b1; done = 1; end
        else begin s = s << 1; e--; ns++; end
      end else begin
        r.res = {sgn, 3'(e), 4'(s - 16)}; done = 1;
      end
    end
    r.lat = 8'(3 + na + ns);
    return r;
  endfunction

  // Cycle-level expectation built from the model's result and latency.
  logic       m_busy, m_valid;
  int         m_left;
  mres_t      m_pend, m_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_left  <= 0;
      m_pend  <= '0;
      m_out   <= '0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_out   <= m_pend;
      end
      m_left <= m_left - 1;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (in_valid) begin
      m_pend <= model(a, b);
      m_left <= int'(model(a, b).lat);
      m_busy <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(!m_busy && !m_valid));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid && out_valid) begin
      chk("cyc_result", 32'(result), 32'(m_out.res));
      chk("cyc_ovf", 32'(ovf), 32'(m_out.ovf));
      chk("cyc_unf", 32'(unf), 32'(m_out.unf));
    end
  end

  typedef struct {
    logic [7:0] a, b, res;
    logic       ovf, unf;
    int         lat;
    bit         hold;
  } vec_t;

  vec_t tbl [14] = '{
    '{8'h30, 8'h30, 8'h40, 1'b0, 1'b0, 4, 1'b0},
    '{8'h30, 8'h20, 8'h38, 1'b0, 1'b0, 4, 1'b0},
    '{8'h20, 8'h30, 8'h38, 1'b0, 1'b0, 4, 1'b0},
    '{8'h30, 8'hB0, 8'h00, 1'b0, 1'b0, 3, 1'b0},
    '{8'h00, 8'hC8, 8'hC8, 1'b0, 1'b0, 1, 1'b0},
    '{8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b0, 3, 1'b0},
    '{8'h30, 8'hAE, 8'h00, 1'b0, 1'b1, 6, 1'b0},
    '{8'h70, 8'h10, 8'h70, 1'b0, 1'b0, 4, 1'b1},
    '{8'h80, 8'h00, 8'h00, 1'b0, 1'b0, 1, 1'b0},
    '{8'hC0, 8'h40, 8'h00, 1'b0, 1'b0, 3, 1'b0},
    '{8'h5A, 8'h3C, 8'h60, 1'b0, 1'b0, 6, 1'b0},
    '{8'h3C, 8'hD2, 8'hC6, 1'b0, 1'b0, 6, 1'b0},
    '{8'h50, 8'h10, 8'h51, 1'b0, 1'b0, 7, 1'b0},
    '{8'h45, 8'h00, 8'h45, 1'b0, 1'b0, 1, 1'b0}
  };

  task automatic run_op(input vec_t v);
    int n;
    mres_t mr;
    mr = model(v.a, v.b);
    chk("model_res", 32'(mr.res), 32'(v.res));
    chk("model_ovf", 32'(mr.ovf), 32'(v.ovf));
    chk("model_lat", 32'(mr.lat), 32'(v.lat));
    n = 0;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1; a = v.a; b = v.b;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'hEE; b = 8'hEE;
    if (v.hold) out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency", 32'(n), 32'(v.lat));
    chk("result", 32'(result), 32'(v.res));
    chk("ovf", 32'(ovf), 32'(v.ovf));
    chk("unf", 32'(unf), 32'(v.unf));
    if (v.hold) begin
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'b1; a = 8'h11; b = 8'h22;
        @(posedge clk); #1;
        chk("hold_result", 32'(result), 32'(v.res));
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("post_handshake_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_unf", 32'(unf), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_op(tbl[i]);

    // Abandon an operation during ALIGN (diff 4 keeps it there several cycles).
    in_valid = 1'b1; a = 8'h50; b = 8'h10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_output", 32'(out_valid), 32'd0);
    end

    run_op(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
